// File: rtl/icu_wide_core.sv
// icu_wide_core: DATA_W-bit industrial control unit core.
// Each instruction takes two enabled clocks. On the FETCH edge the word on
// instr_in is latched into the instruction register. On the EXECUTE edge the
// instruction is applied and the program counter advances.
// The core has an on-chip return-address stack. A JMP pushes the return
// address and an RTN pops it.
//
// Enable semantics: run is a plain clock enable with no handshake. While run is
// low, every register holds its value, including the phase. The one-cycle
// strobes data_we, flgo and flgf are set on an EXECUTE edge and cleared on the
// next FETCH edge. If run is low in between, a strobe stays high until that
// FETCH edge happens.
module icu_wide_core #(
   parameter int DATA_W      = 8,
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              run,
   output logic [PC_W-1:0]   pc_addr,
   input  logic [PC_W+3:0]   instr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_we,
   output logic [DATA_W-1:0] rr,
   output logic              flgo,
   output logic              flgf,
   output logic              skip_out,
   output logic              state_out,
   output logic              stack_err
);

   // Stack pointer counts 0..STACK_DEPTH. Entry indices only need 0..STACK_DEPTH-1.
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
   localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_EXEC  = 1'b1;

   localparam logic [3:0] OP_NOPO = 4'h0;
   localparam logic [3:0] OP_LD   = 4'h1;
   localparam logic [3:0] OP_LDC  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_ANDC = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_ORC  = 4'h6;
   localparam logic [3:0] OP_XNOR = 4'h7;
   localparam logic [3:0] OP_STO  = 4'h8;
   localparam logic [3:0] OP_STOC = 4'h9;
   localparam logic [3:0] OP_IEN  = 4'hA;
   localparam logic [3:0] OP_OEN  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RTN  = 4'hD;
   localparam logic [3:0] OP_SKZ  = 4'hE;
   localparam logic [3:0] OP_NOPF = 4'hF;

   // Architectural registers
   logic [0:0]        r_state;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W+3:0]   r_ir;
   logic [DATA_W-1:0] r_rr;
   logic              r_ien;
   logic              r_oen;
   logic              r_skip;
   logic [DATA_W-1:0] r_data_out;
   logic              r_data_we;
   logic              r_flgo;
   logic              r_flgf;
   logic              r_stack_err;
   logic [SP_W-1:0]   r_sp;
   logic [PC_W-1:0]   r_stack [STACK_DEPTH];

   // Decode / next-state wires
   logic [3:0]        w_opcode;
   logic [PC_W-1:0]   w_operand;
   logic              w_fetch_en;
   logic              w_exec_en;
   logic [DATA_W-1:0] w_d;
   logic [PC_W-1:0]   w_pc_inc;
   logic              w_stack_full;
   logic              w_stack_empty;
   logic [SP_W-1:0]   w_sp_dec;
   logic [IDX_W-1:0]  w_push_idx;
   logic [IDX_W-1:0]  w_pop_idx;
   logic [DATA_W-1:0] w_rr_nxt;
   logic              w_rr_load;
   logic [PC_W-1:0]   w_pc_nxt;
   logic              w_push;
   logic              w_pop;
   logic              w_stack_fault;
   logic              w_store;
   logic [DATA_W-1:0] w_store_val;
   logic              w_ien_load;
   logic              w_oen_load;
   logic              w_skip_set;
   logic              w_nopo;
   logic              w_nopf;

   assign w_opcode      = r_ir[PC_W+3:PC_W];
   assign w_operand     = r_ir[PC_W-1:0];
   assign w_fetch_en    = run && (r_state == ST_FETCH);
   assign w_exec_en     = run && (r_state == ST_EXEC);
   assign w_d           = r_ien ? data_in : '0;
   assign w_pc_inc      = r_pc + PC_ONE;
   assign w_stack_full  = (r_sp == SP_FULL);
   assign w_stack_empty = (r_sp == '0);
   assign w_sp_dec      = r_sp - SP_ONE;
   assign w_push_idx    = r_sp[IDX_W-1:0];
   assign w_pop_idx     = w_sp_dec[IDX_W-1:0];

   // Instruction decode.
   // A pending skip turns the current instruction into a plain PC increment.
   always_comb begin
      w_rr_nxt      = r_rr;
      w_rr_load     = 1'b0;
      w_pc_nxt      = w_pc_inc;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_stack_fault = 1'b0;
      w_store       = 1'b0;
      w_store_val   = r_rr;
      w_ien_load    = 1'b0;
      w_oen_load    = 1'b0;
      w_skip_set    = 1'b0;
      w_nopo        = 1'b0;
      w_nopf        = 1'b0;
      if (!r_skip) begin
         case (w_opcode)
            OP_NOPO: w_nopo = 1'b1;
            OP_LD:   begin w_rr_load = 1'b1; w_rr_nxt = w_d;             end
            OP_LDC:  begin w_rr_load = 1'b1; w_rr_nxt = ~w_d;            end
            OP_AND:  begin w_rr_load = 1'b1; w_rr_nxt = r_rr & w_d;      end
            OP_ANDC: begin w_rr_load = 1'b1; w_rr_nxt = r_rr & ~w_d;     end
            OP_OR:   begin w_rr_load = 1'b1; w_rr_nxt = r_rr | w_d;      end
            OP_ORC:  begin w_rr_load = 1'b1; w_rr_nxt = r_rr | ~w_d;     end
            OP_XNOR: begin w_rr_load = 1'b1; w_rr_nxt = ~(r_rr ^ w_d);   end
            OP_STO:  begin w_store = 1'b1; w_store_val = r_rr;           end
            OP_STOC: begin w_store = 1'b1; w_store_val = ~r_rr;          end
            OP_IEN:  w_ien_load = 1'b1;
            OP_OEN:  w_oen_load = 1'b1;
            OP_JMP: begin
               // The jump is always taken. Only the push is dropped on overflow.
               w_pc_nxt = w_operand;
               if (w_stack_full) w_stack_fault = 1'b1;
               else              w_push        = 1'b1;
            end
            OP_RTN: begin
               // On underflow, fall through to pc+1.
               if (w_stack_empty) begin
                  w_stack_fault = 1'b1;
               end else begin
                  w_pop    = 1'b1;
                  w_pc_nxt = r_stack[w_pop_idx];
               end
            end
            OP_SKZ:  w_skip_set = (r_rr == '0);
            OP_NOPF: w_nopf = 1'b1;
            default: w_nopo = 1'b0;
         endcase
      end
   end

   // Two-phase sequencer: FETCH -> EXECUTE -> FETCH, advancing only while run is high.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)            r_state <= ST_FETCH;
      else if (w_fetch_en) r_state <= ST_EXEC;
      else if (w_exec_en)  r_state <= ST_FETCH;
   end

   // Instruction register: captures the ROM word at the end of FETCH.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)            r_ir <= '0;
      else if (w_fetch_en) r_ir <= instr_in;
   end

   // Program counter: updated once per instruction, on the EXECUTE edge.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)           r_pc <= '0;
      else if (w_exec_en) r_pc <= w_pc_nxt;
   end

   // Result register and the input/output enable latches.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_rr  <= '0;
         r_ien <= 1'b1;
         r_oen <= 1'b1;
      end else if (w_exec_en) begin
         if (w_rr_load)  r_rr  <= w_rr_nxt;
         if (w_ien_load) r_ien <= data_in[0];
         if (w_oen_load) r_oen <= data_in[0];
      end
   end

   // Skip flag: set by SKZ when rr is zero, and consumed by the next EXECUTE.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)           r_skip <= 1'b0;
      else if (w_exec_en) r_skip <= w_skip_set;
   end

   // Store data holds between stores. OEN gates only the write strobe.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)                      r_data_out <= '0;
      else if (w_exec_en && w_store) r_data_out <= w_store_val;
   end

   // One-instruction strobes: set on EXECUTE and cleared on the following FETCH edge.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_data_we <= 1'b0;
         r_flgo    <= 1'b0;
         r_flgf    <= 1'b0;
      end else if (w_fetch_en) begin
         r_data_we <= 1'b0;
         r_flgo    <= 1'b0;
         r_flgf    <= 1'b0;
      end else if (w_exec_en) begin
         r_data_we <= w_store && r_oen;
         r_flgo    <= w_nopo;
         r_flgf    <= w_nopf;
      end
   end

   // Return-address stack: push stores pc+1 at sp and increments; pop decrements.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_sp <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
      end else if (w_exec_en) begin
         if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
            r_sp                <= r_sp + SP_ONE;
         end else if (w_pop) begin
            r_sp <= w_sp_dec;
         end
      end
   end

   // Sticky stack error: only reset clears it.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst)                            r_stack_err <= 1'b0;
      else if (w_exec_en && w_stack_fault) r_stack_err <= 1'b1;
   end

   assign pc_addr   = r_pc;
   assign data_out  = r_data_out;
   assign data_we   = r_data_we;
   assign rr        = r_rr;
   assign flgo      = r_flgo;
   assign flgf      = r_flgf;
   assign skip_out  = r_skip;
   assign state_out = r_state[0];
   assign stack_err = r_stack_err;

endmodule

// File: tb/tb_icu_wide_core.sv
// tb_icu_wide_core: directed bench for icu_wide_core (DATA_W=8, PC_W=8, STACK_DEPTH=4).
// The program ROM is a bench-owned array read combinationally at pc_addr.
// Expected values are pushed into exp_q before the clocks are driven, then
// popped and compared once the DUT has produced its output.
module tb_icu_wide_core;

  logic        clk_in;
  logic        rst;
  logic        run;
  logic [7:0]  pc_addr;
  logic [11:0] instr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_we;
  logic [7:0]  rr;
  logic        flgo;
  logic        flgf;
  logic        skip_out;
  logic        state_out;
  logic        stack_err;

  logic [11:0] rom [256];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_mis = 0;

  localparam logic [3:0] NOPO = 4'h0, LD = 4'h1, LDC = 4'h2, AND = 4'h3, ANDC = 4'h4;
  localparam logic [3:0] OR = 4'h5, ORC = 4'h6, XNOR = 4'h7, STO = 4'h8, STOC = 4'h9;
  localparam logic [3:0] IEN = 4'hA, OEN = 4'hB, JMP = 4'hC, RTN = 4'hD, SKZ = 4'hE, NOPF = 4'hF;

  icu_wide_core #(.DATA_W(8), .PC_W(8), .STACK_DEPTH(4)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .pc_addr   (pc_addr),
    .instr_in  (instr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_we   (data_we),
    .rr        (rr),
    .flgo      (flgo),
    .flgf      (flgf),
    .skip_out  (skip_out),
    .state_out (state_out),
    .stack_err (stack_err)
  );

  assign instr_in = rom[pc_addr];

  // clock / reset block
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic instr_cycle();
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] opd);
    return {op, opd};
  endfunction

  // scoreboard
  task automatic exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_mis++;
      $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic exp_reset_vals();
    exp(0); exp(0); exp(0); exp(0); exp(0); exp(0); exp(0); exp(0); exp(0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc_addr);
    chk({tag, "_rr"}, rr);
    chk({tag, "_state"}, state_out);
    chk({tag, "_dout"}, data_out);
    chk({tag, "_we"}, data_we);
    chk({tag, "_flgo"}, flgo);
    chk({tag, "_flgf"}, flgf);
    chk({tag, "_skip"}, skip_out);
    chk({tag, "_serr"}, stack_err);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    data_in = 8'h00;

    // ---------------- main program: logic ops, store, call/return, skip, gating
    clear_rom();
    rom[0]  = ins(LD, 8'h00);
    rom[1]  = ins(ANDC, 8'hFF);   // operand bits ignored
    rom[2]  = ins(STO, 8'h00);
    rom[3]  = ins(NOPO, 8'h00);
    rom[4]  = ins(NOPF, 8'h00);
    rom[5]  = ins(JMP, 8'h40);
    rom[8'h40] = ins(RTN, 8'h00);
    rom[6]  = ins(LDC, 8'h00);
    rom[7]  = ins(SKZ, 8'h00);
    rom[8]  = ins(JMP, 8'h20);
    rom[9]  = ins(LD, 8'h00);
    rom[10] = ins(SKZ, 8'h00);
    rom[11] = ins(OR, 8'h00);
    rom[12] = ins(XNOR, 8'h00);
    rom[13] = ins(AND, 8'h00);
    rom[14] = ins(STOC, 8'h00);
    rom[15] = ins(OEN, 8'h00);
    rom[16] = ins(STO, 8'h00);
    rom[17] = ins(IEN, 8'h00);
    rom[18] = ins(LD, 8'h00);
    rom[19] = ins(ORC, 8'h00);
    rom[20] = ins(RTN, 8'h00);

    data_in = 8'hA5;
    exp_reset_vals();
    do_reset();
    chk_reset_vals("rst0");

    exp(1); exp(0);
    tick();                                   // FETCH LD
    chk("ld_fetch_state", state_out); chk("ld_fetch_pc", pc_addr);
    exp(8'hA5); exp(1); exp(0);
    tick();                                   // EXECUTE LD
    chk("ld_rr", rr); chk("ld_pc", pc_addr); chk("ld_state", state_out);

    data_in = 8'h0F;
    exp(8'hA0); exp(2);
    instr_cycle();                            // ANDC
    chk("andc_rr", rr); chk("andc_pc", pc_addr);

    exp(0);
    tick();                                   // FETCH STO (clock 5)
    chk("sto_we_c5", data_we);
    exp(1); exp(8'hA0); exp(3);
    tick();                                   // EXECUTE STO (clock 6)
    chk("sto_we_c6", data_we); chk("sto_dout", data_out); chk("sto_pc", pc_addr);
    exp(0); exp(8'hA0);
    tick();                                   // clock 7
    chk("sto_we_c7", data_we); chk("sto_dout_hold", data_out);
    exp(1); exp(4);
    tick();                                   // EXECUTE NOPO
    chk("nopo_flgo", flgo); chk("nopo_pc", pc_addr);
    exp(0);
    tick();                                   // FETCH NOPF
    chk("nopo_flgo_clr", flgo);
    exp(1); exp(0); exp(5);
    tick();                                   // EXECUTE NOPF
    chk("nopf_flgf", flgf); chk("nopf_flgo", flgo); chk("nopf_pc", pc_addr);
    exp(0);
    tick();
    chk("nopf_flgf_clr", flgf);
    exp(8'h40);
    tick();                                   // EXECUTE JMP 0x40
    chk("call_pc", pc_addr);
    exp(6); exp(0);
    instr_cycle();                            // RTN
    chk("ret_pc", pc_addr); chk("ret_serr", stack_err);

    data_in = 8'hFF;
    exp(8'h00); exp(7);
    instr_cycle();                            // LDC
    chk("ldc_rr", rr); chk("ldc_pc", pc_addr);
    exp(1); exp(8);
    instr_cycle();                            // SKZ, rr==0
    chk("skz0_skip", skip_out); chk("skz0_pc", pc_addr);
    exp(1);
    tick();
    chk("skz0_skip_fetch", skip_out);
    exp(9); exp(0);
    tick();                                   // skipped JMP
    chk("skip_jmp_pc", pc_addr); chk("skip_jmp_skip", skip_out);

    data_in = 8'h01;
    exp(8'h01);
    instr_cycle();                            // LD
    chk("ld01_rr", rr);
    exp(0); exp(11);
    instr_cycle();                            // SKZ, rr!=0
    chk("skz1_skip", skip_out); chk("skz1_pc", pc_addr);
    data_in = 8'h80;
    exp(8'h81); exp(12);
    instr_cycle();                            // OR executes
    chk("or_rr", rr); chk("or_pc", pc_addr);
    data_in = 8'h81;
    exp(8'hFF);
    instr_cycle();                            // XNOR
    chk("xnor_rr", rr);
    data_in = 8'h3C;
    exp(8'h3C);
    instr_cycle();                            // AND
    chk("and_rr", rr);
    exp(1); exp(8'hC3);
    instr_cycle();                            // STOC
    chk("stoc_we", data_we); chk("stoc_dout", data_out);

    data_in = 8'h00;
    exp(0);
    instr_cycle();                            // OEN <= 0
    chk("oen_we", data_we);
    exp(0); exp(8'h3C);
    instr_cycle();                            // STO with OEN=0
    chk("sto_oen0_we", data_we); chk("sto_oen0_dout", data_out);
    exp(0);
    tick();
    chk("sto_oen0_we_fetch", data_we);
    tick();                                   // IEN <= 0 (data_in still 0)
    data_in = 8'hFF;
    exp(8'h00);
    instr_cycle();                            // LD masked
    chk("ld_ien0_rr", rr);
    exp(8'hFF);
    instr_cycle();                            // ORC masked -> |~0
    chk("orc_ien0_rr", rr);
    exp(21); exp(1);
    instr_cycle();                            // RTN underflow confirms sp back at 0
    chk("uflow_pc", pc_addr); chk("uflow_serr", stack_err);

    // ---------------- underflow straight after reset
    clear_rom();
    rom[0] = ins(RTN, 8'h00);
    exp(0);
    do_reset();
    chk("rst1_serr", stack_err);
    exp(1); exp(1);
    instr_cycle();
    chk("rtn0_pc", pc_addr); chk("rtn0_serr", stack_err);

    // ---------------- overflow: five nested calls
    clear_rom();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] a;
      a = 8'(i * 16);
      rom[a] = ins(JMP, a + 8'h10);
    end
    rom[8'h50] = ins(RTN, 8'h00);
    rom[8'h31] = ins(NOPF, 8'h00);
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      exp(32'(i * 16)); exp(0);
      instr_cycle();
      chk("call_nest_pc", pc_addr); chk("call_nest_serr", stack_err);
    end
    exp(8'h50); exp(1);
    instr_cycle();                            // fifth call: taken, not pushed
    chk("ovf_pc", pc_addr); chk("ovf_serr", stack_err);
    exp(8'h31); exp(1);
    instr_cycle();                            // returns to fourth call's return address
    chk("ovf_ret_pc", pc_addr); chk("ovf_ret_serr", stack_err);
    exp(1); exp(8'h32);
    instr_cycle();
    chk("ovf_nopf_flgf", flgf); chk("ovf_nopf_pc", pc_addr);

    // ---------------- async reset mid-EXECUTE of STO, then run=0 freeze
    clear_rom();
    rom[0] = ins(LD, 8'h00);
    rom[1] = ins(STO, 8'h00);
    rom[2] = ins(NOPO, 8'h00);
    data_in = 8'h5A;
    do_reset();
    exp(8'h5A);
    instr_cycle();
    chk("r6_ld_rr", rr);
    exp(1); exp(1);
    tick();                                   // FETCH STO
    chk("r6_fetch_state", state_out); chk("r6_fetch_pc", pc_addr);
    exp_reset_vals();
    #3 rst = 1'b0;
    #1;
    chk_reset_vals("arst_exec");
    exp(0);
    tick();
    chk("arst_exec_we_hold", data_we);
    #2 rst = 1'b1;

    exp(8'h5A); exp(1);
    instr_cycle();
    chk("r6b_ld_rr", rr); chk("r6b_pc", pc_addr);
    tick();                                   // FETCH STO
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp(1); exp(1); exp(0);
      tick();
      chk("frz_state", state_out); chk("frz_pc", pc_addr); chk("frz_we", data_we);
    end
    run = 1'b1;
    exp(1); exp(8'h5A); exp(2); exp(0);
    tick();                                   // EXECUTE STO resumes
    chk("res_we", data_we); chk("res_dout", data_out); chk("res_pc", pc_addr); chk("res_state", state_out);
    exp(0); exp(1); exp(2);
    tick();                                   // FETCH NOPO
    chk("res_we_clr", data_we); chk("res_state2", state_out); chk("res_pc2", pc_addr);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp(1); exp(2); exp(0);
      tick();
      chk("frz2_state", state_out); chk("frz2_pc", pc_addr); chk("frz2_flgo", flgo);
    end
    exp_reset_vals();
    #3 rst = 1'b0;
    #1;
    chk_reset_vals("arst_run0");
    tick();
    #2 rst = 1'b1;
    run = 1'b1;
    exp(1); exp(0);
    tick();
    chk("post_state", state_out); chk("post_pc", pc_addr);
    exp(8'h5A); exp(1); exp(0);
    tick();
    chk("post_rr", rr); chk("post_pc2", pc_addr); chk("post_we", data_we);

    // final report
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/icu_wide_core.md
Name: icu_wide_core

Overview:
- Next-generation industrial control unit core, derived from our 1-bit ICU.
- Generalised to a DATA_W-bit result register and bus.
- Adds an on-chip program counter and a return-address stack of STACK_DEPTH entries, replacing the external JMP/RTN flag handshake.
- Sits between a combinational-read program ROM and a DATA_W-bit I/O bus; one instruction completes every two enabled clocks.

Parameters:
DATA_W, 8, width of RR, data_in and data_out
PC_W, 8, program counter / jump operand width
STACK_DEPTH, 4, return stack entries (>=1)

Ports:
clk_in  in  1  clock
rst  in  1  asynchronous, active-low reset
run  in  1  advance enable; low freezes all state (including the phase)
pc_addr  out  PC_W  program address, driven from the PC register
instr_in  in  4+PC_W  {opcode[3:0], operand[PC_W-1:0]}, sampled at end of FETCH
data_in  in  DATA_W  input bus
data_out  out  DATA_W  store data
data_we  out  1  one-cycle write strobe
rr  out  DATA_W  result register
flgo  out  1  NOPO flag pulse
flgf  out  1  NOPF flag pulse
skip_out  out  1  skip pending
state_out  out  1  0=FETCH, 1=EXECUTE
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, rst low):
  - pc=0, rr=0, IEN=1, OEN=1, sp=0, stack entries=0.
  - state=FETCH, skip=0, instruction register=0 (NOPO).
  - data_out=0, data_we=0, flgo=0, flgf=0, stack_err=0.
  - Applies immediately, mid-instruction included; no partial store or stack update survives.
- run=0: no register changes; the next run=1 edge continues the same phase.
- FETCH edge (run=1): IR<=instr_in; data_we, flgo, flgf <=0; state<=EXECUTE.
- EXECUTE edge (run=1): state<=FETCH. The PC update happens here.
  - Default PC update: pc<=pc+1, modulo 2^PC_W.
- Skip: if skip=1 at the EXECUTE edge, the instruction has no effect, pc<=pc+1 and skip<=0. A skipped JMP/RTN does not touch the stack.
- Masked input: D = IEN ? data_in : 0. Complement ops use ~D.
- Opcodes at EXECUTE (bitwise over DATA_W):
  - 0 NOPO: flgo<=1.
  - 1 LD: rr<=D. 2 LDC: rr<=~D.
  - 3 AND: rr<=rr&D. 4 ANDC: rr<=rr&~D.
  - 5 OR: rr<=rr|D. 6 ORC: rr<=rr|~D.
  - 7 XNOR: rr<=~(rr^D).
  - 8 STO: data_out<=rr; data_we<=OEN.
  - 9 STOC: data_out<=~rr; data_we<=OEN.
  - A IEN: IEN<=data_in[0]. B OEN: OEN<=data_in[0].
  - C JMP (call): push pc+1 (wrapped); pc<=operand.
  - D RTN: pop; pc<=popped value.
  - E SKZ: skip<=1 iff rr==0 (all bits); pc<=pc+1.
  - F NOPF: flgf<=1.
- data_we timing: high for exactly the FETCH cycle following the store. data_out holds its value until the next executed STO/STOC, whether or not it was written.
- OEN=0: data_out still updates; data_we stays 0.
- Stack:
  - sp counts 0..STACK_DEPTH.
  - Push when sp==STACK_DEPTH: push dropped, stack_err<=1, jump still taken.
  - Pop when sp==0: stack_err<=1, pc<=pc+1 (fall through).
  - stack_err clears only on reset.
- flgo/flgf are high for exactly the FETCH cycle following their instruction.
- Operand bits are ignored for all opcodes except JMP.

Test Plan:
1. Reset, DATA_W=8, data_in=8'hA5, program LD, ANDC, STO at 0..2, data_in=8'h0F during ANDC -> rr=8'hA0 after ANDC; data_out=8'hA0; data_we high for exactly one cycle, at clock 6; pc_addr steps 0,1,2,3.
2. Call/return: JMP operand 8'h40 at address 5; RTN at 0x40 -> pc_addr goes 5, 0x40, 6; sp returns to 0; stack_err=0.
3. Stack bounds, STACK_DEPTH=4:
   - 5 nested calls -> fifth jumps but is not pushed; stack_err=1.
   - After reset, RTN with sp=0 -> pc=pc+1; stack_err=1.
4. SKZ with rr=0 followed by JMP 0x20 -> JMP suppressed; pc continues sequentially; sp unchanged; skip_out high for one instruction. SKZ with rr=8'h01 -> next instruction executes.
5. OEN/IEN gating:
   - OEN with data_in[0]=0, then STO -> data_we stays 0; data_out=rr.
   - IEN with data_in[0]=0, then LD with data_in=8'hFF -> rr=8'h00.
6. Asynchronous reset asserted mid-EXECUTE of STO, and separately with run=0 held for 3 cycles -> all outputs return to reset values with no data_we pulse; with run=0, pc_addr and state_out are frozen, then resume correctly.
